// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with registered read data and occupancy flags
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   wdata, winc      write data and write request
//   wfull, walmost   full flag and count >= AFULL_TH
//   rinc             read request
//   rdata, rvalid    registered read data; rvalid marks the cycle after an accepted read
//   rempty, ralmost  empty flag and count <= AEMPTY_TH
//   count            occupancy, 0..DEPTH
//   overflow,        sticky error flags, present only when SYNC_FIFO_ERR_EN is defined
//   underflow
module sync_fifo_param #(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 4,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    output logic             wfull,
    output logic             walmost,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    output logic             rempty,
    output logic             ralmost,
`ifdef SYNC_FIFO_ERR_EN
    output logic             overflow,
    output logic             underflow,
`endif
    output logic [ASIZE:0]   count
);
    localparam int DEPTH = 1 << ASIZE;
    logic [DSIZE-1:0] mem [DEPTH];
    logic [ASIZE:0] wptr, rptr;
    logic we, re;
    // Flags come only from the registered count, so no path from winc/rinc reaches them.
    assign wfull   = count == (ASIZE+1)'(DEPTH);
    assign rempty  = count == '0;
    assign walmost = count >= (ASIZE+1)'(AFULL_TH);
    assign ralmost = count <= (ASIZE+1)'(AEMPTY_TH);
    assign we = winc & ~wfull & ~rst;
    assign re = rinc & ~rempty & ~rst;
    // Memory is not reset.
    always_ff @(posedge clk) begin
        if (we) mem[wptr[ASIZE-1:0]] <= wdata;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= re;
            if (we) wptr <= wptr + 1'b1;
            if (re) begin
                rptr  <= rptr + 1'b1;
                rdata <= mem[rptr[ASIZE-1:0]];
            end
            count <= count + {{ASIZE{1'b0}}, we} - {{ASIZE{1'b0}}, re};
        end
    end
`ifdef SYNC_FIFO_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow | (winc & wfull);
            underflow <= underflow | (rinc & rempty);
        end
    end
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed self-checking bench for sync_fifo_param (DEPTH=16)
module tb_sync_fifo_param;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] wdata = '0;
    logic       winc = 1'b0;
    logic       rinc = 1'b0;
    logic       wfull, walmost, rvalid, rempty, ralmost;
    logic [7:0] rdata;
    logic [4:0] count;
`ifdef SYNC_FIFO_ERR_EN
    logic       overflow, underflow;
`endif
    int pass_cnt = 0;
    int total = 0;

    sync_fifo_param #(.DSIZE(8), .ASIZE(4), .AFULL_TH(12), .AEMPTY_TH(2)) dut (
        .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .wfull(wfull),
        .walmost(walmost), .rinc(rinc), .rdata(rdata), .rvalid(rvalid),
        .rempty(rempty), .ralmost(ralmost),
`ifdef SYNC_FIFO_ERR_EN
        .overflow(overflow), .underflow(underflow),
`endif
        .count(count)
    );

    always #5 clk = ~clk;

    // One clock: drive inputs, take the edge, sample 1 time unit later.
    task automatic cycle(input logic w, input logic [7:0] d, input logic r);
        winc = w; wdata = d; rinc = r;
        @(posedge clk);
        #1;
        winc = 1'b0; rinc = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (count !== 5'd0) $display("FAIL reset_count got %0d want 0", count); else pass_cnt++;
        total++; if ({rempty, ralmost, wfull, walmost} !== 4'b1100) $display("FAIL reset_flags got %b want 1100", {rempty, ralmost, wfull, walmost}); else pass_cnt++;
        total++; if ({rvalid, rdata} !== 9'h000) $display("FAIL reset_rdata got %b/%h want 0/00", rvalid, rdata); else pass_cnt++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 8'(i), 1'b0);
            total++; if (count !== 5'(i + 1)) $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); else pass_cnt++;
            total++; if (walmost !== (i + 1 >= 12)) $display("FAIL fill_walmost[%0d] got %b want %b", i, walmost, i + 1 >= 12); else pass_cnt++;
            total++; if (wfull !== (i == 15)) $display("FAIL fill_wfull[%0d] got %b want %b", i, wfull, i == 15); else pass_cnt++;
        end
        cycle(1'b1, 8'hAA, 1'b0);
        total++; if ({wfull, count} !== {1'b1, 5'd16}) $display("FAIL overwrite_ignored got %b/%0d want 1/16", wfull, count); else pass_cnt++;
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            total++; if ({rvalid, rdata} !== {1'b1, 8'(i)}) $display("FAIL drain_data[%0d] got %b/%h want 1/%h", i, rvalid, rdata, 8'(i)); else pass_cnt++;
            total++; if (count !== 5'(15 - i)) $display("FAIL drain_count[%0d] got %0d want %0d", i, count, 15 - i); else pass_cnt++;
            total++; if (ralmost !== (15 - i <= 2)) $display("FAIL drain_ralmost[%0d] got %b want %b", i, ralmost, 15 - i <= 2); else pass_cnt++;
            total++; if (rempty !== (i == 15)) $display("FAIL drain_rempty[%0d] got %b want %b", i, rempty, i == 15); else pass_cnt++;
        end
        cycle(1'b0, 8'h00, 1'b0);
        total++; if ({rvalid, rdata} !== {1'b0, 8'h0F}) $display("FAIL idle_hold got %b/%h want 0/0f", rvalid, rdata); else pass_cnt++;
        cycle(1'b0, 8'h00, 1'b1);
        total++; if ({rvalid, count, rdata} !== {1'b0, 5'd0, 8'h0F}) $display("FAIL read_empty got %b/%0d/%h want 0/0/0f", rvalid, count, rdata); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
        cycle(1'b1, 8'h55, 1'b1);
        total++; if ({count, wfull} !== {5'd15, 1'b0}) $display("FAIL full_rw_count got %0d/%b want 15/0", count, wfull); else pass_cnt++;
        total++; if ({rvalid, rdata} !== {1'b1, 8'h10}) $display("FAIL full_rw_data got %b/%h want 1/10", rvalid, rdata); else pass_cnt++;
        for (int i = 1; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            total++; if (rdata !== 8'(8'h10 + i)) $display("FAIL full_rw_drain[%0d] got %h want %h", i, rdata, 8'(8'h10 + i)); else pass_cnt++;
        end
        total++; if (rempty !== 1'b1) $display("FAIL full_rw_empty got %b want 1", rempty); else pass_cnt++;
        cycle(1'b1, 8'h77, 1'b1);
        total++; if ({count, rvalid, rdata} !== {5'd1, 1'b0, 8'h1F}) $display("FAIL empty_rw got %0d/%b/%h want 1/0/1f", count, rvalid, rdata); else pass_cnt++;
        cycle(1'b0, 8'h00, 1'b1);
        total++; if ({rvalid, rdata, count} !== {1'b1, 8'h77, 5'd0}) $display("FAIL empty_rw_read got %b/%h/%0d want 1/77/0", rvalid, rdata, count); else pass_cnt++;
    endtask

    // 40 words streamed with mixed write/read cycles; expected data and count from a small model.
    task automatic test_wrap();
        int wi = 0, ri = 0, c = 0, t = 0;
        logic w, r, wa, ra;
        do_reset();
        while (ri < 40 && t < 400) begin
            w = (wi < 40) && (c < 10) && (t % 3 != 2);
            r = (c > 0) && (wi == 40 || c >= 5) && (t % 2 == 0);
            wa = w && c < 16;
            ra = r && c > 0;
            cycle(w, 8'(wi * 7 + 3), r);
            if (wa) wi++;
            c = c + int'(wa) - int'(ra);
            total++; if (count !== 5'(c)) $display("FAIL wrap_count[t=%0d] got %0d want %0d", t, count, c); else pass_cnt++;
            total++; if (rvalid !== ra) $display("FAIL wrap_rvalid[t=%0d] got %b want %b", t, rvalid, ra); else pass_cnt++;
            if (ra) begin
                total++; if (rdata !== 8'(ri * 7 + 3)) $display("FAIL wrap_data[%0d] got %h want %h", ri, rdata, 8'(ri * 7 + 3)); else pass_cnt++;
                ri++;
            end
            t++;
        end
        total++; if (ri != 40) $display("FAIL wrap_timeout got %0d reads want 40", ri); else pass_cnt++;
    endtask

    task automatic test_rst_mid();
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        total++; if ({count, rdata} !== {5'd7, 8'hC0}) $display("FAIL pre_rst got %0d/%h want 7/c0", count, rdata); else pass_cnt++;
        rst = 1'b1;
        cycle(1'b1, 8'hEE, 1'b0);
        rst = 1'b0;
        total++; if ({count, rempty, ralmost} !== {5'd0, 1'b1, 1'b1}) $display("FAIL rst_mid_count got %0d/%b/%b want 0/1/1", count, rempty, ralmost); else pass_cnt++;
        total++; if ({rvalid, rdata} !== 9'h000) $display("FAIL rst_mid_rdata got %b/%h want 0/00", rvalid, rdata); else pass_cnt++;
    endtask

`ifdef SYNC_FIFO_ERR_EN
    task automatic test_err();
        do_reset();
        total++; if ({overflow, underflow} !== 2'b00) $display("FAIL err_reset got %b want 00", {overflow, underflow}); else pass_cnt++;
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        total++; if ({overflow, underflow} !== 2'b01) $display("FAIL underflow got %b want 01", {overflow, underflow}); else pass_cnt++;
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0);
        total++; if (overflow !== 1'b0) $display("FAIL no_overflow got %b want 0", overflow); else pass_cnt++;
        cycle(1'b1, 8'hAA, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        total++; if ({overflow, underflow} !== 2'b11) $display("FAIL overflow_sticky got %b want 11", {overflow, underflow}); else pass_cnt++;
        do_reset();
        total++; if ({overflow, underflow} !== 2'b00) $display("FAIL err_clear got %b want 00", {overflow, underflow}); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_rst_mid();
`ifdef SYNC_FIFO_ERR_EN
        test_err();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL have parameter DSIZE, 8, data word width in bits (>=1).
REQ-002 SHALL have parameter ASIZE, 4, address width; depth DEPTH = 2**ASIZE (ASIZE>=1).
REQ-003 SHALL have parameter AFULL_TH, 12, occupancy at or above which walmost is asserted (1..DEPTH).
REQ-004 SHALL have parameter AEMPTY_TH, 2, occupancy at or below which ralmost is asserted (0..DEPTH-1).
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port wdata  input  DSIZE  write data.
REQ-008 SHALL have port winc  input  1  write request.
REQ-009 SHALL have port wfull  output  1  FIFO full.
REQ-010 SHALL have port walmost  output  1  occupancy >= AFULL_TH.
REQ-011 SHALL have port rinc  input  1  read request.
REQ-012 SHALL have port rdata  output  DSIZE  registered read data.
REQ-013 SHALL have port rvalid  output  1  rdata updated this cycle by an accepted read.
REQ-014 SHALL have port rempty  output  1  FIFO empty.
REQ-015 SHALL have port ralmost  output  1  occupancy <= AEMPTY_TH.
REQ-016 SHALL have port count  output  ASIZE+1  current occupancy, 0..DEPTH.

Function
REQ-017 SHALL accept a write when winc=1 and wfull=0: mem[waddr] <= wdata, waddr increments.
REQ-018 SHALL accept a read when rinc=1 and rempty=0: rdata <= mem[raddr] on that edge, raddr increments, rvalid=1 the following cycle; otherwise rvalid=0 and rdata holds.
REQ-019 SHALL ignore winc while wfull=1 and rinc while rempty=1; no pointer, count or memory change.
REQ-020 SHALL keep write/read pointers ASIZE+1 bits wide; address = low ASIZE bits; wrap from DEPTH-1 to 0 with MSB toggle.
REQ-021 SHALL update count: +1 write-only, -1 read-only, unchanged for both or neither accepted.
REQ-022 SHALL derive wfull = (count==DEPTH), rempty = (count==0), walmost = (count>=AFULL_TH), ralmost = (count<=AEMPTY_TH), all from registered count (no combinational path from winc/rinc).
REQ-023 SHALL, when full with winc=rinc=1, accept only the read (count DEPTH-1 next cycle).
REQ-024 SHALL, when empty with winc=rinc=1, accept only the write (count 1 next cycle; no write-through to rdata).
REQ-025 SHALL, with 0<count<DEPTH and winc=rinc=1, accept both; count unchanged; order preserved.
REQ-026 SHALL deliver data strictly in write order across any number of wraps.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, clear pointers and count to 0, rdata to 0, rvalid to 0; rempty=1, ralmost=1, wfull=0, walmost=0 thereafter.
REQ-028 SHALL not reset memory contents; rst has priority over winc/rinc in the same cycle, discarding in-flight data.

Configuration
REQ-029 SHALL, with SYNC_FIFO_ERR_EN defined, add outputs overflow and underflow (1 bit each), sticky-set on winc while wfull and rinc while rempty, cleared only by rst.
REQ-030 SHALL, without SYNC_FIFO_ERR_EN, omit overflow/underflow ports and logic; all other behaviour identical.

Verification (DSIZE=8, ASIZE=4, AFULL_TH=12, AEMPTY_TH=2)
REQ-031 Bench SHALL check: rst, then 16 writes 0x00..0x0F -> wfull=1 after 16th, walmost=1 after 12th, count=16; 17th write 0xAA ignored.
REQ-032 Bench SHALL check: 16 reads from full -> rdata 0x00..0x0F in order, rvalid=1 each following cycle, rempty=1 after last, ralmost=1 at count<=2.
REQ-033 Bench SHALL check: full, winc=rinc=1 one cycle -> count=15, wfull=0, rdata=oldest word; empty, winc=rinc=1 -> count=1, rvalid=0.
REQ-034 Bench SHALL check: 40 writes interleaved with reads holding count 5..10 -> all 40 words read in order across two pointer wraps.
REQ-035 Bench SHALL check: rst asserted at count=7 with winc=1 -> next cycle count=0, rempty=1, rdata=0x00, rvalid=0.
REQ-036 Bench SHALL check (SYNC_FIFO_ERR_EN): write when full -> overflow=1 held until rst; read when empty -> underflow=1 held until rst.
